// File: rtl/move_controller_if.sv
// Bundles the button inputs, game state and board outputs of move_controller.
`timescale 1ns/1ps
interface move_controller_if;
  logic       btnu_mc;
  logic       btnd_mc;
  logic       btnl_mc;
  logic       btnr_mc;
  logic       btnc_mc;
  logic [2:0] gameState_mc;
  logic [0:8] p1Grid_mc;
  logic [0:8] p2Grid_mc;
  logic [3:0] cursor_mc;
  logic       turnToggle_mc;
  logic       occupied_mc;
  logic       locked_mc;

  // Drives buttons and game state, observes the board.
  modport master (
    output btnu_mc, btnd_mc, btnl_mc, btnr_mc, btnc_mc, gameState_mc,
    input  p1Grid_mc, p2Grid_mc, cursor_mc, turnToggle_mc, occupied_mc, locked_mc
  );

  // The controller side.
  modport slave (
    input  btnu_mc, btnd_mc, btnl_mc, btnr_mc, btnc_mc, gameState_mc,
    output p1Grid_mc, p2Grid_mc, cursor_mc, turnToggle_mc, occupied_mc, locked_mc
  );
endinterface

// File: rtl/move_controller.sv
// Turns raw board buttons into cursor moves and piece placements, owns both
// occupancy grids and sequences the turn-change pulse after each placement.
`timescale 1ns/1ps
module move_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [3:0]  SETTLE_CYCLES   = 4'd2
) (
  input logic              clk_mc,
  input logic              rst_n_mc,
  move_controller_if.slave bus
);

  localparam logic [1:0] StReady  = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StToggle = 2'd2;
  localparam logic [1:0] StLocked = 2'd3;

  // Button bit order: [4]=c, [3]=u, [2]=d, [1]=l, [0]=r.
  logic [4:0]  btn_raw;
  logic [4:0]  sync1_q, sync2_q;
  logic [4:0]  stable_q, stable_prev_q;
  logic [15:0] deb_cnt_q [5];
  logic [4:0]  press;

  logic [1:0]  state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [3:0]  cursor_q, cursor_d;
  logic [0:8]  p1_q, p1_d;
  logic [0:8]  p2_q, p2_d;
  logic        occ_q, occ_d;
  logic        game_over;
  logic        cell_free;

  assign btn_raw = {bus.btnc_mc, bus.btnu_mc, bus.btnd_mc, bus.btnl_mc, bus.btnr_mc};

  // Synchronize each button and accept a level only after it has held long enough.
  always_ff @(posedge clk_mc or negedge rst_n_mc) begin
    if (!rst_n_mc) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
          stable_q[i]  <= ~stable_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Only rising edges of the accepted level count as presses.
  assign press = stable_q & ~stable_prev_q;

  assign game_over = (bus.gameState_mc >= 3'd2);
  assign cell_free = ~(p1_q[cursor_q] | p2_q[cursor_q]);

  function automatic logic [3:0] move_up(input logic [3:0] c);
    return (c < 4'd3) ? c + 4'd6 : c - 4'd3;
  endfunction

  function automatic logic [3:0] move_down(input logic [3:0] c);
    return (c > 4'd5) ? c - 4'd6 : c + 4'd3;
  endfunction

  function automatic logic [3:0] move_left(input logic [3:0] c);
    return ((c % 4'd3) == 4'd0) ? c + 4'd2 : c - 4'd1;
  endfunction

  function automatic logic [3:0] move_right(input logic [3:0] c);
    return ((c % 4'd3) == 4'd2) ? c - 4'd2 : c + 4'd1;
  endfunction

  // Next-state logic: one action per cycle, center has the highest priority.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cursor_d = cursor_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    occ_d    = 1'b0;
    case (state_q)
      StReady: begin
        if (game_over) begin
          state_d = StLocked;
        end else if (press[4]) begin
          if (cell_free) begin
            if (bus.gameState_mc == 3'd0) p1_d[cursor_q] = 1'b1;
            else                          p2_d[cursor_q] = 1'b1;
            settle_d = SETTLE_CYCLES;
            state_d  = StSettle;
          end else begin
            occ_d = 1'b1;
          end
        end else if (press[3]) begin
          cursor_d = move_up(cursor_q);
        end else if (press[2]) begin
          cursor_d = move_down(cursor_q);
        end else if (press[1]) begin
          cursor_d = move_left(cursor_q);
        end else if (press[0]) begin
          cursor_d = move_right(cursor_q);
        end
      end
      // Give gameStatus time to judge the new grid before the turn flips.
      StSettle: begin
        if (settle_q == 4'd0) state_d = game_over ? StLocked : StToggle;
        else                  settle_d = settle_q - 4'd1;
      end
      StToggle: state_d = StReady;
      StLocked: state_d = StLocked;
      default:  state_d = StReady;
    endcase
  end

  // Board and FSM state registers.
  always_ff @(posedge clk_mc or negedge rst_n_mc) begin
    if (!rst_n_mc) begin
      state_q  <= StReady;
      settle_q <= '0;
      cursor_q <= 4'd4;
      p1_q     <= '0;
      p2_q     <= '0;
      occ_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cursor_q <= cursor_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      occ_q    <= occ_d;
    end
  end

  assign bus.p1Grid_mc     = p1_q;
  assign bus.p2Grid_mc     = p2_q;
  assign bus.cursor_mc     = cursor_q;
  assign bus.turnToggle_mc = (state_q == StToggle);
  assign bus.occupied_mc   = occ_q;
  assign bus.locked_mc     = (state_q == StLocked);

endmodule
